r2r_dac_sequencer: RTL and testbench

//  Sample-rate sequencer for the 4-bit R2R DAC. It sits between the digital
//  pad logic and the DAC bit inputs b0..b3, and drives r2r_out at a

---
 rtl/r2r_dac_sequencer_if.sv | 30 +++
 rtl/r2r_dac_sequencer.sv | 120 ++++++++++++
 tb/tb_r2r_dac_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/r2r_dac_sequencer_if.sv
// Pad-side bus of the R2R DAC sequencer: control, FIFO write handshake and DAC outputs.
// The master drives control/write data; the sequencer (slave) drives the DAC code and status.
interface r2r_dac_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int DIV_W = 8
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [1:0]       mode;
  logic             load_divider;
  logic [DIV_W-1:0] div_value;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] r2r_out;
  logic             sample_tick;
  logic             underrun;
  logic [LVL_W-1:0] fifo_level;

  modport master (
    output mode, load_divider, div_value, in_valid, in_data,
    input  in_ready, r2r_out, sample_tick, underrun, fifo_level
  );

  modport slave (
    input  mode, load_divider, div_value, in_valid, in_data,
    output in_ready, r2r_out, sample_tick, underrun, fifo_level
  );
endinterface

// File: rtl/r2r_dac_sequencer.sv
// Sample-rate sequencer for the 4-bit R2R DAC: programmable divider picks the sample instants,
// each sample sourced from a small FIFO, a ramp, a triangle or the direct input nibble.
module r2r_dac_sequencer #(
  parameter int          WIDTH   = 4,
  parameter int          DEPTH   = 4,
  parameter int          DIV_W   = 8,
  parameter int unsigned DIV_RST = 9
) (
  input  logic                  clk,
  input  logic                  n_rst,
  r2r_dac_sequencer_if.slave    bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    MODE_FIFO   = 2'b00,
    MODE_RAMP   = 2'b01,
    MODE_TRI    = 2'b10,
    MODE_DIRECT = 2'b11
  } mode_e;

  typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_e;

  mode_e            mode;
  dir_e             dir_q, dir_d;
  logic [DIV_W-1:0] cnt, div_reg;
  logic [WIDTH-1:0] r2r_q, r2r_d;
  logic             und_d, sample_tick_q, underrun_q;
  logic             tick, push, pop, fifo_empty, fifo_full, in_ready;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;

  assign mode       = mode_e'(bus.mode);
  // A load restarts the count, so it also suppresses a tick that would land on that cycle.
  assign tick       = !bus.load_divider && (cnt == '0);
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(DEPTH));
  assign in_ready   = !fifo_full && (mode != MODE_DIRECT);
  // Pop uses pre-push occupancy: data pushed on a tick cycle is only seen on the next tick.
  assign push       = bus.in_valid && in_ready;
  assign pop        = tick && (mode == MODE_FIFO) && !fifo_empty;

  assign bus.in_ready    = in_ready;
  assign bus.r2r_out     = r2r_q;
  assign bus.sample_tick = sample_tick_q;
  assign bus.underrun    = underrun_q;
  assign bus.fifo_level  = level;

  always_comb begin
    r2r_d = r2r_q;
    dir_d = dir_q;
    und_d = 1'b0;
    if (tick) begin
      unique case (mode)
        MODE_FIFO: begin
          if (fifo_empty) und_d = 1'b1;
          else            r2r_d = mem[rd_ptr];
        end
        MODE_RAMP: r2r_d = r2r_q + WIDTH'(1);
        MODE_TRI: begin
          if (r2r_q == '1) begin
            dir_d = DIR_DN;
            r2r_d = r2r_q - WIDTH'(1);
          end else if (r2r_q == '0) begin
            dir_d = DIR_UP;
            r2r_d = WIDTH'(1);
          end else if (dir_q == DIR_UP) begin
            r2r_d = r2r_q + WIDTH'(1);
          end else begin
            r2r_d = r2r_q - WIDTH'(1);
          end
        end
        MODE_DIRECT: r2r_d = bus.in_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r2r_q         <= '0;
      dir_q         <= DIR_UP;
      cnt           <= DIV_W'(DIV_RST);
      div_reg       <= DIV_W'(DIV_RST);
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      sample_tick_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      r2r_q         <= r2r_d;
      dir_q         <= dir_d;
      sample_tick_q <= tick;
      underrun_q    <= und_d;
      if (bus.load_divider) begin
        div_reg <= bus.div_value;
        cnt     <= bus.div_value;
      end else if (cnt == '0) begin
        cnt <= div_reg;
      end else begin
        cnt <= cnt - DIV_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end
endmodule

// File: tb/tb_r2r_dac_sequencer.sv
// Randomized bench for r2r_dac_sequencer: a sample-level reference model predicts every tick
// and pushes it into a scoreboard; a negedge monitor pops and compares on sample_tick.
module tb_r2r_dac_sequencer;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int DIV_W = 8;

  logic clk = 1'b0;
  logic n_rst;

  r2r_dac_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_W(DIV_W)) bus ();

  r2r_dac_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_W(DIV_W), .DIV_RST(9)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct { int val; bit und; } samp_t;

  int    n_checks = 0;
  int    n_errors = 0;
  bit    armed = 0;

  // reference model state
  int    mval;
  bit    mdown;
  int    since;
  int    period;
  int    fq[$];
  samp_t expq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: a sample is due every period+1 clocks counted from the last reset, load or sample.
  always @(posedge clk) begin
    if (!n_rst) begin
      mval = 0; mdown = 0; since = 0; period = 9;
      fq.delete(); expq.delete();
      armed = 1;
    end else begin
      bit    tk;
      bit    do_push;
      samp_t s;
      do_push = bus.in_valid && (fq.size() < DEPTH) && (bus.mode != 2'b11);
      tk = 0;
      if (bus.load_divider) begin
        period = int'(bus.div_value);
        since  = 0;
      end else begin
        since++;
        if (since == period + 1) begin
          tk = 1;
          since = 0;
        end
      end
      if (tk) begin
        s.und = 0;
        case (bus.mode)
          2'b00: if (fq.size() == 0) s.und = 1; else mval = fq.pop_front();
          2'b01: mval = (mval + 1) % 16;
          2'b10: begin
            if (mval == 15)      begin mdown = 1; mval = 14; end
            else if (mval == 0)  begin mdown = 0; mval = 1;  end
            else                 mval = mdown ? mval - 1 : mval + 1;
          end
          default: mval = int'(bus.in_data);
        endcase
        s.val = mval;
        expq.push_back(s);
      end
      if (do_push) fq.push_back(int'(bus.in_data));
    end
  end

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("fifo_level", int'(bus.fifo_level), fq.size());
      chk("in_ready", int'(bus.in_ready), int'(fq.size() < DEPTH && bus.mode != 2'b11));
      chk("r2r_hold", int'(bus.r2r_out), mval);
      if (bus.sample_tick) begin
        if (expq.size() == 0) begin
          chk("spurious_tick", 1, 0);
        end else begin
          samp_t e;
          e = expq.pop_front();
          chk("tick_value", int'(bus.r2r_out), e.val);
          chk("tick_underrun", int'(bus.underrun), int'(e.und));
        end
      end else begin
        chk("underrun_idle", int'(bus.underrun), 0);
        if (expq.size() != 0) begin
          chk("missed_tick", 0, 1);
          expq.delete();
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic load_div(input int v);
    bus.load_divider = 1'b1;
    bus.div_value    = DIV_W'(v);
    cyc(1);
    bus.load_divider = 1'b0;
  endtask

  initial begin
    int pre[4];
    pre = '{3, 7, 11, 15};
    n_rst = 1'b0;
    bus.mode = 2'b01; bus.load_divider = 1'b0; bus.div_value = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    cyc(2);
    n_rst = 1'b1;

    // ramp at the reset rate
    cyc(200);
    // triangle at full rate
    bus.mode = 2'b10;
    load_div(0);
    cyc(45);
    // prefill during ramp, then drain in FIFO mode past empty
    bus.mode = 2'b01;
    load_div(9);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(pre[i % 4]);
      cyc(1);
    end
    bus.in_valid = 1'b0;
    bus.mode = 2'b00;
    cyc(70);
    // FIFO streaming at div=3
    load_div(3);
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'($urandom_range(15));
      cyc(1);
      bus.in_valid = 1'b0;
      cyc(3);
    end
    // direct mode
    bus.mode = 2'b11;
    for (int i = 0; i < 12; i++) begin
      bus.in_data  = WIDTH'((i % 2) ? 5 : 10);
      bus.in_valid = 1'b1;
      cyc(5);
    end
    bus.in_valid = 1'b0;
    // reset mid-stream with data in the FIFO
    bus.mode = 2'b01;
    load_div(9);
    bus.in_valid = 1'b1; bus.in_data = 4'h9; cyc(1);
    bus.in_data = 4'h2; cyc(1);
    bus.in_valid = 1'b0;
    cyc(3);
    n_rst = 1'b0;
    cyc(2);
    n_rst = 1'b1;
    cyc(25);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) bus.mode = 2'($urandom_range(3));
      bus.in_valid     = 1'($urandom_range(1));
      bus.in_data      = WIDTH'($urandom_range(15));
      bus.load_divider = ($urandom_range(59) == 0);
      bus.div_value    = DIV_W'($urandom_range(5));
      n_rst            = ($urandom_range(599) != 0);
      cyc(1);
    end
    n_rst = 1'b1;
    bus.load_divider = 1'b0;
    bus.in_valid = 1'b0;
    cyc(20);
    chk("scoreboard_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
